// File: rtl/ram_ctrl.sv
// -----------------------------------------------------------------------------
// ram_ctrl
//   Request/response front end for a single-port synchronous RAM. A request is
//   accepted in IDLE and is turned into one memory beat (or, with burst
//   support, req_len+1 consecutive beats). Each beat gives one response on the
//   rsp_* port. A beat whose address is >= DEPTH never touches the RAM and
//   returns rsp_err=1.
//
//   Optional feature macro: RAM_CTRL_BURST_EN
//     undefined : req_len is ignored and every request is a single beat.
//     defined   : request runs req_len+1 beats at incrementing addresses
//                 (wrapping modulo 2^ADDR_W). Writes fill every beat with the
//                 same wdata.
//
//   Ports
//     clk, reset        single clock, synchronous active-high reset
//     req_valid/ready   request handshake; ready only while IDLE
//     req_write         1 = write/fill, 0 = read
//     req_addr          start address
//     req_wdata         write data
//     req_len           beats minus one (burst builds only)
//     rsp_valid/ready   response handshake
//     rsp_rdata         read data (0 for writes and errors)
//     rsp_err           beat address out of range
//     rsp_last          final beat of the request
//     mem_*             RAM port; mem_data_out valid one cycle after
//                       mem_read_enable
//     busy              high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module ram_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_last,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    RWAIT,
    RESP
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic              advance;
  logic              last_beat;

  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  // Next beat address; the natural ADDR_W-bit overflow gives the wrap.
  assign addr_inc = addr_q + ADDR_W'(1);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
  endfunction

  // First state of a beat: out-of-range beats skip the RAM entirely.
  function automatic state_t beat_state(input logic w, input logic [ADDR_W-1:0] a);
    if (!in_range(a)) return RESP;
    return w ? WRITE : READ;
  endfunction

`ifdef RAM_CTRL_BURST_EN
  logic [1:0] beats_left;
  assign last_beat = (beats_left == 2'd0);
`else
  assign last_beat = 1'b1;
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  // Next-state logic.
  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = beat_state(req_write, req_addr);
        end
      end
      WRITE: state_next = RESP;
      READ:  state_next = RWAIT;
      RWAIT: state_next = RESP;
      RESP: begin
        if (rsp_ready) begin
          if (last_beat) begin
            state_next = IDLE;
          end else begin
            advance    = 1'b1;
            state_next = beat_state(wr_q, addr_inc);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and beat datapath.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef RAM_CTRL_BURST_EN
      beats_left <= 2'd0;
`endif
    end else begin
      state <= state_next;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= !in_range(req_addr);
        rdata_q <= '0;
`ifdef RAM_CTRL_BURST_EN
        beats_left <= req_len;
`endif
      end
      if (advance) begin
        addr_q  <= addr_inc;
        err_q   <= !in_range(addr_inc);
        rdata_q <= '0;
`ifdef RAM_CTRL_BURST_EN
        beats_left <= beats_left - 2'd1;
`endif
      end
      // RAM data is valid the cycle after the read strobe, i.e. in RWAIT.
      if (state == RWAIT) begin
        rdata_q <= mem_data_out;
      end
    end
  end

  // Outputs are gated with reset so nothing is requested or presented while an
  // abandoned operation is being flushed.
  assign req_ready        = (state == IDLE)  && !reset;
  assign busy             = (state != IDLE)  && !reset;
  assign rsp_valid        = (state == RESP)  && !reset;
  assign mem_write_enable = (state == WRITE) && !reset;
  assign mem_read_enable  = (state == READ)  && !reset;
  assign mem_address      = addr_q;
  assign mem_data_in      = wdata_q;
  assign rsp_rdata        = rdata_q;
  assign rsp_err          = err_q;
  assign rsp_last         = rsp_valid && last_beat;

endmodule
